alu_execute_unit: RTL and testbench

Execute-stage arithmetic block for the single-cycle RISC-V datapath. It decodes the 3-bit ALU operation class and the instruction funct3 into a 4-bit ALU control code, and performs the selected 32-bit ALU operation with a zero flag. It also computes the two PC adders: sequential PC+4 and branch target PC+immediate. All results are registered once so that downstream logic sees a clean, resettable interface.

---
 rtl/alu_execute_unit_if.sv | 26 ++
 rtl/alu_execute_unit.sv | 89 ++++++++
 tb/tb_alu_execute_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_execute_unit_if.sv
// rtl/alu_execute_unit_if.sv - operand/control request and registered result bundle for the execute stage
interface alu_execute_unit_if;
  logic        in_valid;
  logic [2:0]  alu_op;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] pc;
  logic [31:0] immediate;
  logic        out_valid;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  modport master (
    output in_valid, alu_op, funct3, operand_a, operand_b, pc, immediate,
    input  out_valid, alu_control, alu_result, zero, pc_plus4, branch_target
  );

  modport slave (
    input  in_valid, alu_op, funct3, operand_a, operand_b, pc, immediate,
    output out_valid, alu_control, alu_result, zero, pc_plus4, branch_target
  );
endinterface

// File: rtl/alu_execute_unit.sv
// rtl/alu_execute_unit.sv - ALU control decode, 32-bit ALU, PC adders, one register stage
module alu_execute_unit (
  input  logic               clk,
  input  logic               reset,
  alu_execute_unit_if.slave  bus
);
  localparam logic [3:0] alu_and  = 4'b0000;
  localparam logic [3:0] alu_or   = 4'b0001;
  localparam logic [3:0] alu_add  = 4'b0010;
  localparam logic [3:0] alu_xor  = 4'b0011;
  localparam logic [3:0] alu_sll  = 4'b0100;
  localparam logic [3:0] alu_srl  = 4'b0101;
  localparam logic [3:0] alu_sub  = 4'b0110;
  localparam logic [3:0] alu_slt  = 4'b0111;
  localparam logic [3:0] alu_sra  = 4'b1000;
  localparam logic [3:0] alu_sltu = 4'b1001;

  logic [3:0]  ctrl;
  logic [31:0] result;
  logic [4:0]  shamt;

  assign shamt = bus.operand_b[4:0];

  always_comb begin
    ctrl = alu_add;
    case (bus.alu_op)
      3'b001: ctrl = alu_sub;
      3'b010, 3'b100: begin
        case (bus.funct3)
          3'b000:  ctrl = alu_add;
          3'b001:  ctrl = alu_sll;
          3'b010:  ctrl = alu_slt;
          3'b011:  ctrl = alu_sltu;
          3'b100:  ctrl = alu_xor;
          3'b101:  ctrl = alu_srl;
          3'b110:  ctrl = alu_or;
          default: ctrl = alu_and;
        endcase
      end
      3'b011: begin
        if (bus.funct3 == 3'b000)
          ctrl = alu_sub;
        else if (bus.funct3 == 3'b101)
          ctrl = alu_sra;
        else
          ctrl = alu_add;
      end
      default: ctrl = alu_add;
    endcase
  end

  always_comb begin
    result = 32'd0;
    case (ctrl)
      alu_and:  result = bus.operand_a & bus.operand_b;
      alu_or:   result = bus.operand_a | bus.operand_b;
      alu_add:  result = bus.operand_a + bus.operand_b;
      alu_xor:  result = bus.operand_a ^ bus.operand_b;
      alu_sll:  result = bus.operand_a << shamt;
      alu_srl:  result = bus.operand_a >> shamt;
      alu_sub:  result = bus.operand_a - bus.operand_b;
      alu_slt:  result = {31'd0, $signed(bus.operand_a) < $signed(bus.operand_b)};
      alu_sra:  result = $unsigned($signed(bus.operand_a) >>> shamt);
      alu_sltu: result = {31'd0, bus.operand_a < bus.operand_b};
      default:  result = 32'd0;
    endcase
  end

  // Data registers only load on valid cycles; out_valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.alu_control   <= 4'd0;
      bus.alu_result    <= 32'd0;
      bus.zero          <= 1'b0;
      bus.pc_plus4      <= 32'd0;
      bus.branch_target <= 32'd0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.alu_control   <= ctrl;
        bus.alu_result    <= result;
        bus.zero          <= (result == 32'd0);
        bus.pc_plus4      <= bus.pc + 32'd4;
        bus.branch_target <= bus.pc + bus.immediate;
      end
    end
  end
endmodule

// File: tb/tb_alu_execute_unit.sv
// tb/tb_alu_execute_unit.sv - directed self-checking bench for alu_execute_unit
module tb_alu_execute_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  alu_execute_unit_if bus ();

  alu_execute_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] imm);
    bus.in_valid  = v;
    bus.alu_op    = op;
    bus.funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.pc        = p;
    bus.immediate = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 3'b010, 3'b000, 32'h5, 32'h6, 32'h10, 32'h20);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.alu_result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", bus.alu_result); end
    total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL rst_zero got=%b exp=0", bus.zero); end
    total++; if (bus.pc_plus4 !== 32'h0 || bus.branch_target !== 32'h0 || bus.alu_control !== 4'h0) begin
      bad++; $display("FAIL rst_misc got=%h/%h/%h exp=0/0/0", bus.pc_plus4, bus.branch_target, bus.alu_control);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_wrap;
    drive(1'b1, 3'b010, 3'b000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    total++; if (bus.alu_control !== 4'b0010) begin bad++; $display("FAIL add_ctrl got=%b exp=0010", bus.alu_control); end
    total++; if (bus.alu_result !== 32'h0) begin bad++; $display("FAIL add_result got=%h exp=0", bus.alu_result); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL add_zero got=%b exp=1", bus.zero); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
  endtask

  task automatic test_branch_sub;
    drive(1'b1, 3'b001, 3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'hFFFFFFF8);
    total++; if (bus.alu_control !== 4'b0110) begin bad++; $display("FAIL br_ctrl got=%b exp=0110", bus.alu_control); end
    total++; if (bus.alu_result !== 32'h0 || bus.zero !== 1'b1) begin
      bad++; $display("FAIL br_result got=%h zero=%b exp=0 zero=1", bus.alu_result, bus.zero);
    end
    total++; if (bus.branch_target !== 32'hF8) begin bad++; $display("FAIL br_target got=%h exp=000000f8", bus.branch_target); end
    total++; if (bus.pc_plus4 !== 32'h104) begin bad++; $display("FAIL br_pc4 got=%h exp=00000104", bus.pc_plus4); end
    drive(1'b1, 3'b001, 3'b000, 32'h5, 32'h7, 32'hFFFFFFFC, 32'h8);
    total++; if (bus.alu_result !== 32'hFFFFFFFE || bus.zero !== 1'b0) begin
      bad++; $display("FAIL br_neg got=%h zero=%b exp=fffffffe zero=0", bus.alu_result, bus.zero);
    end
    total++; if (bus.pc_plus4 !== 32'h0 || bus.branch_target !== 32'h4) begin
      bad++; $display("FAIL pc_wrap got=%h/%h exp=0/4", bus.pc_plus4, bus.branch_target);
    end
  endtask

  task automatic test_compare;
    drive(1'b1, 3'b010, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'h1 || bus.alu_control !== 4'b0111) begin
      bad++; $display("FAIL slt got=%h ctrl=%b exp=1 ctrl=0111", bus.alu_result, bus.alu_control);
    end
    drive(1'b1, 3'b010, 3'b011, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'h0 || bus.alu_control !== 4'b1001 || bus.zero !== 1'b1) begin
      bad++; $display("FAIL sltu got=%h ctrl=%b zero=%b exp=0 ctrl=1001 zero=1", bus.alu_result, bus.alu_control, bus.zero);
    end
    drive(1'b1, 3'b100, 3'b011, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'h1) begin bad++; $display("FAIL sltu_itype got=%h exp=1", bus.alu_result); end
  endtask

  task automatic test_shifts;
    drive(1'b1, 3'b010, 3'b101, 32'h80000000, 32'h24, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'h08000000 || bus.alu_control !== 4'b0101) begin
      bad++; $display("FAIL srl got=%h ctrl=%b exp=08000000 ctrl=0101", bus.alu_result, bus.alu_control);
    end
    drive(1'b1, 3'b011, 3'b101, 32'h80000000, 32'h24, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'hF8000000 || bus.alu_control !== 4'b1000) begin
      bad++; $display("FAIL sra got=%h ctrl=%b exp=f8000000 ctrl=1000", bus.alu_result, bus.alu_control);
    end
    drive(1'b1, 3'b010, 3'b001, 32'h80000000, 32'h24, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'h0 || bus.alu_control !== 4'b0100 || bus.zero !== 1'b1) begin
      bad++; $display("FAIL sll got=%h ctrl=%b exp=0 ctrl=0100", bus.alu_result, bus.alu_control);
    end
  endtask

  task automatic test_logic;
    drive(1'b1, 3'b010, 3'b111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'h00F000F0 || bus.alu_control !== 4'b0000) begin
      bad++; $display("FAIL and got=%h ctrl=%b exp=00f000f0 ctrl=0000", bus.alu_result, bus.alu_control);
    end
    drive(1'b1, 3'b100, 3'b110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'hFFF0FFF0 || bus.alu_control !== 4'b0001) begin
      bad++; $display("FAIL or got=%h ctrl=%b exp=fff0fff0 ctrl=0001", bus.alu_result, bus.alu_control);
    end
    drive(1'b1, 3'b010, 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0);
    total++; if (bus.alu_result !== 32'hFF00FF00 || bus.alu_control !== 4'b0011) begin
      bad++; $display("FAIL xor got=%h ctrl=%b exp=ff00ff00 ctrl=0011", bus.alu_result, bus.alu_control);
    end
    drive(1'b1, 3'b000, 3'b111, 32'h3, 32'h4, 32'h0, 32'h0);
    total++; if (bus.alu_control !== 4'b0010 || bus.alu_result !== 32'h7) begin
      bad++; $display("FAIL op000 got ctrl=%b res=%h exp ctrl=0010 res=7", bus.alu_control, bus.alu_result);
    end
    drive(1'b1, 3'b111, 3'b001, 32'h3, 32'h4, 32'h0, 32'h0);
    total++; if (bus.alu_control !== 4'b0010 || bus.alu_result !== 32'h7) begin
      bad++; $display("FAIL op111 got ctrl=%b res=%h exp ctrl=0010 res=7", bus.alu_control, bus.alu_result);
    end
    drive(1'b1, 3'b011, 3'b000, 32'h3, 32'h4, 32'h0, 32'h0);
    total++; if (bus.alu_control !== 4'b0110 || bus.alu_result !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL op011_sub got ctrl=%b res=%h exp ctrl=0110 res=ffffffff", bus.alu_control, bus.alu_result);
    end
    drive(1'b1, 3'b011, 3'b111, 32'h3, 32'h4, 32'h0, 32'h0);
    total++; if (bus.alu_control !== 4'b0010 || bus.alu_result !== 32'h7) begin
      bad++; $display("FAIL op011_add got ctrl=%b res=%h exp ctrl=0010 res=7", bus.alu_control, bus.alu_result);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 3'b010, 3'b000, 32'd10, 32'd20, 32'h200, 32'h10);
    total++; if (bus.alu_result !== 32'd30 || bus.out_valid !== 1'b1 || bus.branch_target !== 32'h210) begin
      bad++; $display("FAIL b2b_0 got=%h v=%b bt=%h exp=1e v=1 bt=210", bus.alu_result, bus.out_valid, bus.branch_target);
    end
    drive(1'b1, 3'b100, 3'b110, 32'h0F, 32'hF0, 32'h204, 32'h0);
    total++; if (bus.alu_result !== 32'hFF || bus.out_valid !== 1'b1 || bus.pc_plus4 !== 32'h208) begin
      bad++; $display("FAIL b2b_1 got=%h v=%b pc4=%h exp=ff v=1 pc4=208", bus.alu_result, bus.out_valid, bus.pc_plus4);
    end
    drive(1'b0, 3'b001, 3'b000, 32'h1, 32'h1, 32'h999, 32'h1);
    total++; if (bus.out_valid !== 1'b0 || bus.alu_result !== 32'hFF || bus.alu_control !== 4'b0001 || bus.pc_plus4 !== 32'h208 || bus.zero !== 1'b0) begin
      bad++; $display("FAIL hold got v=%b res=%h ctrl=%b pc4=%h z=%b exp v=0 res=ff ctrl=0001 pc4=208 z=0",
                      bus.out_valid, bus.alu_result, bus.alu_control, bus.pc_plus4, bus.zero);
    end
  endtask

  task automatic test_reset_hold;
    drive(1'b1, 3'b010, 3'b000, 32'h11, 32'h22, 32'h300, 32'h40);
    total++; if (bus.alu_result !== 32'h33 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL pre_rst got=%h v=%b exp=33 v=1", bus.alu_result, bus.out_valid);
    end
    reset = 1'b1;
    drive(1'b1, 3'b010, 3'b000, 32'h1, 32'h2, 32'h400, 32'h4);
    total++; if (bus.out_valid !== 1'b0 || bus.alu_result !== 32'h0 || bus.zero !== 1'b0 || bus.pc_plus4 !== 32'h0 ||
                 bus.branch_target !== 32'h0 || bus.alu_control !== 4'h0) begin
      bad++; $display("FAIL mid_rst got v=%b res=%h z=%b pc4=%h bt=%h ctrl=%b exp all 0", bus.out_valid, bus.alu_result,
                      bus.zero, bus.pc_plus4, bus.branch_target, bus.alu_control);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b010, 3'(i), 32'h100 + 32'(i), 32'h7, 32'h500, 32'h8);
      total++; if (bus.out_valid !== 1'b0 || bus.alu_result !== 32'h0 || bus.zero !== 1'b0 || bus.pc_plus4 !== 32'h0 ||
                   bus.branch_target !== 32'h0 || bus.alu_control !== 4'h0) begin
        bad++; $display("FAIL idle_%0d got v=%b res=%h z=%b pc4=%h bt=%h exp all 0", i, bus.out_valid, bus.alu_result,
                        bus.zero, bus.pc_plus4, bus.branch_target);
      end
    end
    drive(1'b1, 3'b010, 3'b000, 32'h2, 32'h3, 32'h8, 32'h0);
    total++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'h5) begin
      bad++; $display("FAIL post_rst got v=%b res=%h exp v=1 res=5", bus.out_valid, bus.alu_result);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.alu_op = 3'd0; bus.funct3 = 3'd0;
    bus.operand_a = 32'd0; bus.operand_b = 32'd0; bus.pc = 32'd0; bus.immediate = 32'd0;
    test_reset();
    test_add_wrap();
    test_branch_sub();
    test_compare();
    test_shifts();
    test_logic();
    test_back_to_back();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
